// File: rtl/neuron_feeder.sv
// -----------------------------------------------------------------------------
// neuron_feeder
// Sequencer for the input side of a single time-multiplexed neuron. For each of
// N_NEURONS classes it clears the neuron, streams N_INPUTS back-to-back beats of
// {pixel, weight, bias} read from synchronous ROMs, then waits for the neuron's
// result strobe (or a timeout) and reports the result.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   start             begin one inference (honoured only while idle)
//   busy, done, err   status: not idle / end-of-inference pulse / sticky timeout
//   pix_addr/pix_data pixel ROM (1-cycle read latency)
//   w_addr/w_data     weight ROM, address {neuron, index} (1-cycle latency)
//   b_addr/b_data     bias ROM, address = neuron (1-cycle latency)
//   nrn_reset         synchronous clear to the neuron
//   inp_ready         beat valid; inp_data/weight/bias are ROM pass-throughs
//   nrn_out_ready/nrn_out   neuron result strobe and value
//   result_valid/result_idx/result_data   one-cycle result report
// -----------------------------------------------------------------------------
module neuron_feeder #(
  parameter int N_INPUTS  = 784,
  parameter int ADDR_W    = 10,
  parameter int N_NEURONS = 10,
  parameter int NRN_W     = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [ADDR_W-1:0]       pix_addr,
  input  logic [15:0]             pix_data,
  output logic [NRN_W+ADDR_W-1:0] w_addr,
  input  logic [15:0]             w_data,
  output logic [NRN_W-1:0]        b_addr,
  input  logic [15:0]             b_data,
  output logic                    nrn_reset,
  output logic                    inp_ready,
  output logic [15:0]             inp_data,
  output logic [15:0]             weight,
  output logic [15:0]             bias,
  input  logic                    nrn_out_ready,
  input  logic [7:0]              nrn_out,
  output logic                    result_valid,
  output logic [NRN_W-1:0]        result_idx,
  output logic [7:0]              result_data
);

  localparam int WT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(N_INPUTS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [NRN_W-1:0]  LAST_NRN  = NRN_W'(N_NEURONS - 1);
  localparam logic [NRN_W-1:0]  NRN_ONE   = NRN_W'(1);
  localparam logic [WT_W-1:0]   LAST_WAIT = WT_W'(TIMEOUT - 1);
  localparam logic [WT_W-1:0]   WAIT_ONE  = WT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLR    = 2'd1,
    S_STREAM = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [NRN_W-1:0]    nrn_q, nrn_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   beat_q, beat_d;
  logic [WT_W-1:0]     wait_q, wait_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                inp_ready_q, inp_ready_d;
  logic                nrn_reset_q, nrn_reset_d;
  logic                rv_q, rv_d;
  logic [NRN_W-1:0]    ridx_q, ridx_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                adv_nrn_s;

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d   = state_q;
    nrn_d     = nrn_q;
    addr_d    = addr_q;
    beat_d    = beat_q;
    wait_d    = wait_q;
    err_d     = err_q;
    done_d    = 1'b0;
    rv_d      = 1'b0;
    ridx_d    = ridx_q;
    rdata_d   = rdata_q;
    adv_nrn_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
          nrn_d   = {NRN_W{1'b0}};
          addr_d  = {ADDR_W{1'b0}};
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR: begin
        // Address 0 is on the bus this cycle; the first beat needs address 1 next.
        state_d = S_STREAM;
        beat_d  = {ADDR_W{1'b0}};
        addr_d  = (addr_q < LAST_BEAT) ? (addr_q + ADDR_ONE) : addr_q;
      end
      S_STREAM: begin
        // Prefetch address saturates at the last index rather than wrapping.
        addr_d = (addr_q < LAST_BEAT) ? (addr_q + ADDR_ONE) : addr_q;
        beat_d = beat_q + ADDR_ONE;
        if (beat_q == LAST_BEAT) begin
          state_d = S_WAIT;
          wait_d  = {WT_W{1'b0}};
        end else begin
          state_d = S_STREAM;
        end
      end
      S_WAIT: begin
        if (nrn_out_ready) begin
          rv_d      = 1'b1;
          ridx_d    = nrn_q;
          rdata_d   = nrn_out;
          adv_nrn_s = 1'b1;
        end else if (wait_q == LAST_WAIT) begin
          err_d     = 1'b1;
          rv_d      = 1'b1;
          ridx_d    = nrn_q;
          rdata_d   = 8'h00;
          adv_nrn_s = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Leaving WAIT: either the next neuron's CLR or back to idle with done.
    if (adv_nrn_s) begin
      addr_d = {ADDR_W{1'b0}};
      if (nrn_q == LAST_NRN) begin
        state_d = S_IDLE;
        nrn_d   = {NRN_W{1'b0}};
        done_d  = 1'b1;
      end else begin
        state_d = S_CLR;
        nrn_d   = nrn_q + NRN_ONE;
      end
    end else begin
      done_d = 1'b0;
    end

    // Status outputs are registered from the next state so they align with it.
    busy_d      = (state_d != S_IDLE);
    inp_ready_d = (state_d == S_STREAM);
    nrn_reset_d = (state_d == S_IDLE) || (state_d == S_CLR);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      nrn_q       <= {NRN_W{1'b0}};
      addr_q      <= {ADDR_W{1'b0}};
      beat_q      <= {ADDR_W{1'b0}};
      wait_q      <= {WT_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      inp_ready_q <= 1'b0;
      nrn_reset_q <= 1'b1;
      rv_q        <= 1'b0;
      ridx_q      <= {NRN_W{1'b0}};
      rdata_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      nrn_q       <= nrn_d;
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      inp_ready_q <= inp_ready_d;
      nrn_reset_q <= nrn_reset_d;
      rv_q        <= rv_d;
      ridx_q      <= ridx_d;
      rdata_q     <= rdata_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign pix_addr     = addr_q;
  assign w_addr       = {nrn_q, addr_q};
  assign b_addr       = nrn_q;
  assign nrn_reset    = nrn_reset_q;
  assign inp_ready    = inp_ready_q;
  assign inp_data     = pix_data;
  assign weight       = w_data;
  assign bias         = b_data;
  assign result_valid = rv_q;
  assign result_idx   = ridx_q;
  assign result_data  = rdata_q;

endmodule

// File: tb/tb_neuron_feeder.sv
module tb_neuron_feeder;

  localparam int N_INPUTS  = 784;
  localparam int ADDR_W    = 10;
  localparam int N_NEURONS = 10;
  localparam int NRN_W     = 4;
  localparam int TIMEOUT   = 15;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    start;
  logic                    busy, done, err;
  logic [ADDR_W-1:0]       pix_addr;
  logic [15:0]             pix_data = 16'h0000;
  logic [NRN_W+ADDR_W-1:0] w_addr;
  logic [15:0]             w_data = 16'h0000;
  logic [NRN_W-1:0]        b_addr;
  logic [15:0]             b_data = 16'h0000;
  logic                    nrn_reset, inp_ready;
  logic [15:0]             inp_data, weight, bias;
  logic                    nrn_out_ready = 1'b0;
  logic [7:0]              nrn_out = 8'h00;
  logic                    result_valid;
  logic [NRN_W-1:0]        result_idx;
  logic [7:0]              result_data;

  neuron_feeder #(
    .N_INPUTS(N_INPUTS), .ADDR_W(ADDR_W), .N_NEURONS(N_NEURONS),
    .NRN_W(NRN_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
    .pix_addr(pix_addr), .pix_data(pix_data), .w_addr(w_addr), .w_data(w_data),
    .b_addr(b_addr), .b_data(b_data), .nrn_reset(nrn_reset), .inp_ready(inp_ready),
    .inp_data(inp_data), .weight(weight), .bias(bias),
    .nrn_out_ready(nrn_out_ready), .nrn_out(nrn_out),
    .result_valid(result_valid), .result_idx(result_idx), .result_data(result_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Stimulus configuration (written only by the main initial block).
  bit flat      = 1'b0;
  bit no_strobe = 1'b0;
  int spur_cyc  = -1;
  int base      = 0;
  int edge_cnt  = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ROM models: flat (0x0100 everywhere) or ramp (pix=i, w=n*1024+i, b=0x1000+n).
  always @(posedge clk) begin
    pix_data <= flat ? 16'h0100 : {6'b0, pix_addr};
    w_data   <= flat ? 16'h0100 : {2'b0, w_addr};
    b_data   <= flat ? 16'h0000 : {12'h100, b_addr};
  end

  // Neuron model: strobes one cycle after the last beat, result 0xA0+neuron.
  int m_beats = 0;
  int m_n     = 0;
  always @(posedge clk) begin
    bit last;
    last = 1'b0;
    if (!busy) begin
      m_beats = 0;
      m_n     = -1;
    end else if (nrn_reset) begin
      m_beats = 0;
      m_n     = m_n + 1;
    end else if (inp_ready) begin
      m_beats = m_beats + 1;
      last    = (m_beats == N_INPUTS);
    end
    #1;
    nrn_out_ready = 1'b0;
    if (last && !no_strobe) begin
      nrn_out_ready = 1'b1;
      nrn_out       = 8'hA0 + 8'(m_n);
    end
    if ((edge_cnt - base) == spur_cyc) nrn_out_ready = 1'b1;
  end

  // Monitor (cycle c = edges since the start edge, start edge -> cycle 1).
  int ir_cnt = 0, clr_cnt = 0, rv_cnt = 0, done_cnt = 0, done_cyc = 0;
  int beat_bad = 0, nr_bad = 0, beat_k = 0, nb_first = 0, cur_n = 0;
  bit prev_clr = 1'b0, busy_prev = 1'b0;
  int b0_cyc [256];
  int rv_cyc [256];
  int rv_idx [256];
  int rv_dat [256];

  always @(negedge clk) begin
    int c;
    logic [15:0] ep, ew, eb;
    c = edge_cnt - base;
    if (busy && nrn_reset) begin
      if (busy_prev && beat_k != N_INPUTS) beat_bad++;
      if (inp_ready) nr_bad++;
      cur_n    = busy_prev ? cur_n + 1 : 0;
      clr_cnt++;
      beat_k   = 0;
      prev_clr = 1'b1;
    end else begin
      if (prev_clr && !inp_ready) nr_bad++;
      prev_clr = 1'b0;
    end
    if (!busy && (!nrn_reset || inp_ready)) nr_bad++;
    if (inp_ready && !nrn_reset) begin
      if (beat_k == 0) begin
        nb_first = c;
        if (clr_cnt > 0 && clr_cnt <= 256) b0_cyc[clr_cnt-1] = c;
      end
      ep = flat ? 16'h0100 : 16'(beat_k);
      ew = flat ? 16'h0100 : 16'(cur_n * 1024 + beat_k);
      eb = flat ? 16'h0000 : 16'(16'h1000 + cur_n);
      if (inp_data !== ep || weight !== ew || bias !== eb) beat_bad++;
      if (beat_k == N_INPUTS - 1 && (c - nb_first) != N_INPUTS - 1) beat_bad++;
      if (beat_k >= N_INPUTS) beat_bad++;
      beat_k++;
      ir_cnt++;
    end
    if (result_valid && rv_cnt < 256) begin
      rv_cyc[rv_cnt] = c;
      rv_idx[rv_cnt] = int'(result_idx);
      rv_dat[rv_cnt] = int'(result_data);
      rv_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = c;
      if (beat_k != N_INPUTS) beat_bad++;
    end
    busy_prev = busy;
  end

  // One full inference with the given ROM/neuron behaviour and expected timing.
  task automatic run_inf(input string tag, input bit f, input bit ns, input int hold,
                         input int spur, input int period, input bit exp_err);
    int s_ir, s_clr, s_rv, s_done, s_bb, s_nb, c;
    s_ir = ir_cnt; s_clr = clr_cnt; s_rv = rv_cnt; s_done = done_cnt;
    s_bb = beat_bad; s_nb = nr_bad;
    flat = f; no_strobe = ns; spur_cyc = spur;
    @(negedge clk);
    base  = edge_cnt;
    start = 1'b1;
    c = 0;
    while (done_cnt == s_done && c < 12000) begin
      @(negedge clk);
      #1;
      c = edge_cnt - base;
      if (c >= hold) start = 1'b0;
    end
    start = 1'b0;
    check_eq({tag, "/done_seen"}, 32'(done_cnt - s_done), 32'd1);
    repeat (5) @(negedge clk);
    #1;
    check_eq({tag, "/first_beat"}, 32'(b0_cyc[s_clr]), 32'd2);
    check_eq({tag, "/clr_cycles"}, 32'(clr_cnt - s_clr), 32'(N_NEURONS));
    check_eq({tag, "/beats"}, 32'(ir_cnt - s_ir), 32'(N_NEURONS * N_INPUTS));
    check_eq({tag, "/beat_errs"}, 32'(beat_bad - s_bb), 32'd0);
    check_eq({tag, "/nrn_reset_errs"}, 32'(nr_bad - s_nb), 32'd0);
    check_eq({tag, "/results"}, 32'(rv_cnt - s_rv), 32'(N_NEURONS));
    for (int k = 0; k < N_NEURONS; k++) begin
      check_eq($sformatf("%s/rv_cyc%0d", tag, k), 32'(rv_cyc[s_rv+k]), 32'(1 + period * (k + 1)));
      check_eq($sformatf("%s/rv_idx%0d", tag, k), 32'(rv_idx[s_rv+k]), 32'(k));
      check_eq($sformatf("%s/rv_dat%0d", tag, k), 32'(rv_dat[s_rv+k]),
               ns ? 32'd0 : 32'(8'hA0 + k));
    end
    check_eq({tag, "/done_cyc"}, 32'(done_cyc), 32'(1 + N_NEURONS * period));
    check_eq({tag, "/done_cnt"}, 32'(done_cnt - s_done), 32'd1);
    check_eq({tag, "/busy_after"}, 32'(busy), 32'd0);
    check_eq({tag, "/err"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    int s_rv, s_done;
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst/busy", 32'(busy), 32'd0);
    check_eq("rst/done", 32'(done), 32'd0);
    check_eq("rst/err", 32'(err), 32'd0);
    check_eq("rst/inp_ready", 32'(inp_ready), 32'd0);
    check_eq("rst/nrn_reset", 32'(nrn_reset), 32'd1);
    check_eq("rst/result_valid", 32'(result_valid), 32'd0);
    check_eq("rst/addrs", 32'({pix_addr, w_addr, b_addr}), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_inf("flat", 1'b1, 1'b0, 1, -1, 786, 1'b0);
    run_inf("ramp", 1'b0, 1'b0, 1, -1, 786, 1'b0);
    run_inf("timeout", 1'b0, 1'b1, 1, -1, 786 + TIMEOUT - 1, 1'b1);
    run_inf("err_clear", 1'b0, 1'b0, 1, -1, 786, 1'b0);
    run_inf("held_start", 1'b0, 1'b0, 5000, 400, 786, 1'b0);

    // Abort at neuron 3, beat 400 (cycle 2760) with an asynchronous reset.
    s_rv = rv_cnt; s_done = done_cnt;
    flat = 1'b0; no_strobe = 1'b0; spur_cyc = -1;
    @(negedge clk);
    base  = edge_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while ((edge_cnt - base) < 2760) @(negedge clk);
    #1;
    check_eq("abort/pre_beat", 32'(beat_k), 32'd401);
    reset = 1'b0;
    #1;
    check_eq("abort/busy", 32'(busy), 32'd0);
    check_eq("abort/inp_ready", 32'(inp_ready), 32'd0);
    check_eq("abort/nrn_reset", 32'(nrn_reset), 32'd1);
    check_eq("abort/outs", 32'({done, err, result_valid, result_idx, result_data}), 32'd0);
    check_eq("abort/addrs", 32'({pix_addr, w_addr, b_addr}), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check_eq("abort/results", 32'(rv_cnt - s_rv), 32'd3);
    check_eq("abort/no_done", 32'(done_cnt - s_done), 32'd0);

    run_inf("fresh", 1'b0, 1'b0, 1, -1, 786, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neuron_feeder.md
Name: neuron_feeder

Overview:
- Sequencer that drives the input side of the neuron datapath.
- Reads Q8.8 pixels, per-neuron weights and biases from synchronous ROMs.
- Streams each neuron's input vector as N_INPUTS back-to-back beats, waits for the neuron's out_ready, then records the result.
- Time-multiplexes one neuron instance across N_NEURONS output classes, one inference per start.

Parameters:
- N_INPUTS, 784, beats per neuron (28x28 pixels).
- ADDR_W, 10, pixel/weight index width.
- N_NEURONS, 10, neurons evaluated per inference.
- NRN_W, 4, neuron index width.
- TIMEOUT, 15, max WAIT cycles before error.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin inference; sampled only in IDLE.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at end of inference.
- err  out  1  sticky WAIT timeout flag; cleared on accepted start.
- pix_addr  out  ADDR_W  pixel ROM address.
- pix_data  in  16  pixel ROM data, Q8.8, valid 1 cycle after address.
- w_addr  out  NRN_W+ADDR_W  weight ROM address {neuron, index}.
- w_data  in  16  weight ROM data, 1-cycle latency.
- b_addr  out  NRN_W  bias ROM address.
- b_data  in  16  bias ROM data, 1-cycle latency.
- nrn_reset  out  1  active-high synchronous clear to neuron.
- inp_ready  out  1  beat valid to neuron.
- inp_data  out  16  pixel to neuron (pix_data pass-through).
- weight  out  16  weight to neuron (w_data pass-through).
- bias  out  16  bias to neuron (b_data pass-through).
- nrn_out_ready  in  1  neuron result strobe.
- nrn_out  in  8  neuron result.
- result_valid  out  1  one-cycle result pulse.
- result_idx  out  NRN_W  neuron index of result.
- result_data  out  8  captured nrn_out.

Behaviour:
- Reset (async, reset=0): state IDLE, all counters 0. Outputs: busy=0, done=0, err=0, inp_ready=0, result_valid=0, result_idx=0, result_data=0, all addresses 0, nrn_reset=1. Mid-operation reset aborts immediately; no result or done is emitted.
- States: IDLE, CLR, STREAM, WAIT.
- IDLE:
  - nrn_reset=1.
  - start=1 -> CLR with n=0; err cleared.
  - start is ignored in all other states.
- CLR (1 cycle):
  - nrn_reset=1.
  - Issues pix_addr=0, w_addr={n,0}, b_addr=n.
  - Loads beat counter k=0 -> STREAM.
- STREAM:
  - nrn_reset=0 and inp_ready=1 every cycle, no bubbles.
  - Beat k presents data fetched by the previous cycle's address. Address for k+1 is issued in the same cycle.
  - b_addr is held at n, so bias is stable for all beats.
  - After beat N_INPUTS-1 (N_INPUTS beats total) -> WAIT.
  - Address counter stops at N_INPUTS-1; no wrap.
- WAIT:
  - inp_ready=0.
  - nrn_out_ready=1: capture result_idx=n and result_data=nrn_out; result_valid=1 on the next cycle.
  - Then -> CLR with n+1, or, if n==N_NEURONS-1, -> IDLE with done=1 in the same cycle as the final result_valid.
  - nrn_out_ready=0 for TIMEOUT consecutive cycles: err=1, result_data=0, result_valid pulsed, sequence continues as above.
- nrn_out_ready outside WAIT is ignored.
- Timing per neuron: 1 CLR + N_INPUTS STREAM + WAIT cycles.
  - Start sampled at edge 0; CLR at cycle 1; beats at cycles 2..785.
  - Neuron strobe at 786; result_valid at 787.
  - With an immediate strobe, neuron k result_valid is at 787+786k.
- Arithmetic: pass-through only; no width change on data.

Test Plan:
- Reset then start pulse; ROM pixel=0x0100, weight=0x0100, bias=0; neuron model strobes 1 cycle after last beat -> 784 contiguous inp_ready cycles at 2..785; result_valid idx 0..9 at 787+786k; done at 7861; busy low after.
- Ramp ROMs (pix[i]=i, w[n][i]=n*1024+i) -> beat k carries inp_data=k and weight=n*1024+k; no skipped or duplicated beats; bias==b[n] throughout.
- Neuron never strobes -> err=1 after 15 WAIT cycles; result_data=0 per neuron; done still pulses; next start clears err.
- start held high during busy, and a spurious nrn_out_ready during STREAM -> no restart, no extra result_valid.
- Assert reset at neuron 3 beat 400 -> all outputs at reset values within the same cycle; no done; fresh start runs a full correct sequence.
- nrn_reset high in IDLE and CLR, low during STREAM/WAIT; exactly one CLR cycle between neurons.
